// File: rtl/rvfi_feeder_pkg.sv
// Shared types for the RVFI-to-ISS feeder: the FIFO entry layout and the replay FSM states.
package rvfi_feeder_pkg;

  localparam int unsigned RVFI_XLEN = 32;

  typedef struct packed {
    logic [63:0]          order;
    logic [RVFI_XLEN-1:0] pc;
    logic [31:0]          insn;
    logic                 trap;
    logic                 intr;
    logic [31:0]          irq;
  } rvfi_entry_t;

  localparam int unsigned ENTRY_W = $bits(rvfi_entry_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INTR = 2'd1,
    STEP = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/rvfi_iss_feeder_if.sv
// Retirement capture and ISS request/handshake signals; master is the feeder, slave is core+ISS.
interface rvfi_iss_feeder_if
  import rvfi_feeder_pkg::*;
#(
  parameter int unsigned XLEN = RVFI_XLEN
);

  logic            rvfi_valid_i;
  logic [63:0]     rvfi_order_i;
  logic [XLEN-1:0] rvfi_pc_i;
  logic [31:0]     rvfi_insn_i;
  logic            rvfi_trap_i;
  logic            rvfi_intr_i;
  logic [31:0]     rvfi_irq_i;

  logic            intr_valid_o;
  logic            intr_ready_i;
  logic [31:0]     intr_irq_o;

  logic            step_valid_o;
  logic            step_ready_i;
  logic [63:0]     step_order_o;
  logic [XLEN-1:0] step_pc_o;
  logic [31:0]     step_insn_o;
  logic            step_trap_o;

  modport master (
    input  rvfi_valid_i, rvfi_order_i, rvfi_pc_i, rvfi_insn_i,
    input  rvfi_trap_i, rvfi_intr_i, rvfi_irq_i,
    input  intr_ready_i, step_ready_i,
    output intr_valid_o, intr_irq_o,
    output step_valid_o, step_order_o, step_pc_o, step_insn_o, step_trap_o
  );

  modport slave (
    output rvfi_valid_i, rvfi_order_i, rvfi_pc_i, rvfi_insn_i,
    output rvfi_trap_i, rvfi_intr_i, rvfi_irq_i,
    output intr_ready_i, step_ready_i,
    input  intr_valid_o, intr_irq_o,
    input  step_valid_o, step_order_o, step_pc_o, step_insn_o, step_trap_o
  );

endinterface

// File: rtl/rvfi_feeder_fifo.sv
// Generic synchronous FIFO of packed entries; head and the entry behind it come straight from storage.
module rvfi_feeder_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_idx, rd_next_idx, wr_idx;
  logic             do_push, do_pop;

  assign wr_idx      = wr_ptr_q[AW-1:0];
  assign rd_idx      = rd_ptr_q[AW-1:0];
  assign rd_next_idx = rd_idx + 1'b1;

  // Same index with differing wrap bits means the write pointer has lapped the read pointer.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o  = mem_q[rd_idx];
  assign next_o  = mem_q[rd_next_idx];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_idx] = push_data_i;
      wr_ptr_d      = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rvfi_iss_feeder.sv
// Buffers RVFI retirements and replays them to the ISS as optional intr request followed by a step.
module rvfi_iss_feeder
  import rvfi_feeder_pkg::*;
#(
  parameter int unsigned XLEN  = RVFI_XLEN,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rvfi_iss_feeder_if.master      bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   order_err_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  feeder_state_e state_q, state_d;
  logic          overflow_q, overflow_d;
  logic          order_err_q, order_err_d;
  logic          seen_q, seen_d;
  logic [63:0]   expected_q, expected_d;

  rvfi_entry_t          push_entry, head, next_entry;
  logic [ENTRY_W-1:0]   head_bits, next_bits;
  logic                 fifo_full, fifo_empty, pop, push_ok;
  logic [CW-1:0]        fifo_count;
  logic                 nh_avail, nh_intr;
  logic                 unused_next_fields;

  always_comb begin
    push_entry.order = bus.rvfi_order_i;
    push_entry.pc    = bus.rvfi_pc_i[XLEN-1:0];
    push_entry.insn  = bus.rvfi_insn_i;
    push_entry.trap  = bus.rvfi_trap_i;
    push_entry.intr  = bus.rvfi_intr_i;
    push_entry.irq   = bus.rvfi_irq_i;
  end

  assign pop     = (state_q == STEP) && bus.step_ready_i;
  assign push_ok = bus.rvfi_valid_i && (!fifo_full || pop);

  rvfi_feeder_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (bus.rvfi_valid_i),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_bits),
    .next_o      (next_bits),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign head       = head_bits;
  assign next_entry = next_bits;
  assign unused_next_fields = ^{next_entry.order, next_entry.pc, next_entry.insn,
                                next_entry.trap, next_entry.irq};

  // Look ahead to whichever entry will be at the head next cycle, including one being
  // pushed into an otherwise drained FIFO, so back-to-back steps need no idle bubble.
  always_comb begin
    nh_avail = pop ? (fifo_count > CW'(1)) : !fifo_empty;
    nh_intr  = pop ? next_entry.intr : head.intr;
    if (!nh_avail) begin
      nh_avail = push_ok;
      nh_intr  = bus.rvfi_intr_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (nh_avail) state_d = nh_intr ? INTR : STEP;
      INTR: if (bus.intr_ready_i) state_d = STEP;
      STEP: if (pop) state_d = nh_avail ? (nh_intr ? INTR : STEP) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d  = overflow_q | (bus.rvfi_valid_i && !push_ok);
    order_err_d = order_err_q;
    seen_d      = seen_q;
    expected_d  = expected_q;
    if (push_ok) begin
      if (seen_q && (bus.rvfi_order_i != expected_q)) begin
        order_err_d = 1'b1;
      end
      seen_d     = 1'b1;
      expected_d = bus.rvfi_order_i + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      overflow_q  <= 1'b0;
      order_err_q <= 1'b0;
      seen_q      <= 1'b0;
      expected_q  <= '0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      order_err_q <= order_err_d;
      seen_q      <= seen_d;
      expected_q  <= expected_d;
    end
  end

  // Payloads are gated by state so idle outputs read zero regardless of stale storage.
  always_comb begin
    bus.intr_valid_o = 1'b0;
    bus.intr_irq_o   = '0;
    bus.step_valid_o = 1'b0;
    bus.step_order_o = '0;
    bus.step_pc_o    = '0;
    bus.step_insn_o  = '0;
    bus.step_trap_o  = 1'b0;
    unique case (state_q)
      INTR: begin
        bus.intr_valid_o = 1'b1;
        bus.intr_irq_o   = head.irq;
      end
      STEP: begin
        bus.step_valid_o = 1'b1;
        bus.step_order_o = head.order;
        bus.step_pc_o    = head.pc;
        bus.step_insn_o  = head.insn;
        bus.step_trap_o  = head.trap;
      end
      default: ;
    endcase
  end

  assign count_o     = fifo_count;
  assign overflow_o  = overflow_q;
  assign order_err_o = order_err_q;

endmodule

// File: tb/tb_rvfi_iss_feeder.sv
// Directed self-checking bench for rvfi_iss_feeder: streaming, intr ordering, overflow, order check, reset.
module tb_rvfi_iss_feeder;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count;
  logic       overflow, order_err;
  int         checks = 0;
  int         failures = 0;

  rvfi_iss_feeder_if #(.XLEN(32)) bus ();

  rvfi_iss_feeder #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .count_o     (count),
    .overflow_o  (overflow),
    .order_err_o (order_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [63:0] order, input logic intr, input logic [31:0] irq);
    bus.rvfi_valid_i = valid;
    bus.rvfi_order_i = order;
    bus.rvfi_pc_i    = 32'h1000 + order[31:0] * 4;
    bus.rvfi_insn_i  = 32'h0000_0013;
    bus.rvfi_trap_i  = 1'b0;
    bus.rvfi_intr_i  = intr;
    bus.rvfi_irq_i   = irq;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 32'd0);
    bus.intr_ready_i = 1'b0;
    bus.step_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 32'd0);
    bus.intr_ready_i = 1'b0;
    bus.step_ready_i = 1'b0;
    tick();
    tick();
    checks++; if (bus.intr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_intr_valid got=%b exp=0", bus.intr_valid_o); end
    checks++; if (bus.step_valid_o !== 1'b0) begin failures++; $display("FAIL reset_step_valid got=%b exp=0", bus.step_valid_o); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0 || order_err !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b%b exp=00", overflow, order_err); end
    checks++; if (bus.step_order_o !== 64'd0) begin failures++; $display("FAIL reset_step_order got=%0h exp=0", bus.step_order_o); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    bus.step_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 64'(k), 1'b0, 32'd0);
      tick();
      checks++; if (bus.step_valid_o !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, bus.step_valid_o); end
      checks++; if (bus.step_order_o !== 64'(k)) begin failures++; $display("FAIL stream_order[%0d] got=%0d exp=%0d", k, bus.step_order_o, k); end
      checks++; if (bus.step_pc_o !== 32'h1000 + 32'(k) * 4) begin failures++; $display("FAIL stream_pc[%0d] got=%0h exp=%0h", k, bus.step_pc_o, 32'h1000 + 32'(k) * 4); end
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count); end
    end
    drive(1'b0, 64'd0, 1'b0, 32'd0);
    tick();
    checks++; if (bus.step_valid_o !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL stream_drain got=valid%b count%0d exp=valid0 count0", bus.step_valid_o, count); end
    checks++; if (overflow !== 1'b0 || order_err !== 1'b0) begin failures++; $display("FAIL stream_sticky got=%b%b exp=00", overflow, order_err); end
  endtask

  task automatic test_intr();
    do_reset();
    drive(1'b1, 64'd10, 1'b1, 32'h800);
    tick();
    drive(1'b0, 64'd0, 1'b0, 32'd0);
    checks++; if (bus.intr_valid_o !== 1'b1 || bus.step_valid_o !== 1'b0) begin failures++; $display("FAIL intr_first got=intr%b step%b exp=intr1 step0", bus.intr_valid_o, bus.step_valid_o); end
    checks++; if (bus.intr_irq_o !== 32'h800) begin failures++; $display("FAIL intr_irq got=%0h exp=800", bus.intr_irq_o); end
    tick();
    checks++; if (bus.intr_valid_o !== 1'b1 || bus.intr_irq_o !== 32'h800) begin failures++; $display("FAIL intr_hold got=valid%b irq%0h exp=valid1 irq800", bus.intr_valid_o, bus.intr_irq_o); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL intr_count got=%0d exp=1", count); end
    bus.intr_ready_i = 1'b1;
    tick();
    bus.intr_ready_i = 1'b0;
    checks++; if (bus.intr_valid_o !== 1'b0 || bus.step_valid_o !== 1'b1) begin failures++; $display("FAIL intr_then_step got=intr%b step%b exp=intr0 step1", bus.intr_valid_o, bus.step_valid_o); end
    checks++; if (bus.step_order_o !== 64'd10 || count !== 4'd1) begin failures++; $display("FAIL intr_step_order got=order%0d count%0d exp=order10 count1", bus.step_order_o, count); end
    bus.step_ready_i = 1'b1;
    tick();
    bus.step_ready_i = 1'b0;
    checks++; if (bus.step_valid_o !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL intr_pop got=valid%b count%0d exp=valid0 count0", bus.step_valid_o, count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.intr_ready_i = 1'b1;
    bus.step_ready_i = 1'b1;
    drive(1'b1, 64'd40, 1'b1, 32'h80);
    tick();
    checks++; if (bus.intr_valid_o !== 1'b1 || bus.intr_irq_o !== 32'h80) begin failures++; $display("FAIL b2b_intr got=valid%b irq%0h exp=valid1 irq80", bus.intr_valid_o, bus.intr_irq_o); end
    drive(1'b1, 64'd41, 1'b0, 32'd0);
    tick();
    drive(1'b0, 64'd0, 1'b0, 32'd0);
    checks++; if (bus.step_valid_o !== 1'b1 || bus.step_order_o !== 64'd40 || count !== 4'd2) begin failures++; $display("FAIL b2b_step40 got=valid%b order%0d count%0d exp=valid1 order40 count2", bus.step_valid_o, bus.step_order_o, count); end
    tick();
    checks++; if (bus.step_valid_o !== 1'b1 || bus.step_order_o !== 64'd41 || count !== 4'd1) begin failures++; $display("FAIL b2b_step41 got=valid%b order%0d count%0d exp=valid1 order41 count1", bus.step_valid_o, bus.step_order_o, count); end
    tick();
    checks++; if (bus.step_valid_o !== 1'b0 || bus.intr_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_idle got=step%b intr%b exp=00", bus.step_valid_o, bus.intr_valid_o); end
    bus.intr_ready_i = 1'b0;
    bus.step_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k <= DEPTH; k++) begin
      drive(1'b1, 64'(20 + k), 1'b0, 32'd0);
      tick();
    end
    drive(1'b0, 64'd0, 1'b0, 32'd0);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (order_err !== 1'b0) begin failures++; $display("FAIL ovf_order_err got=%b exp=0", order_err); end
    checks++; if (bus.step_order_o !== 64'd20) begin failures++; $display("FAIL ovf_head got=%0d exp=20", bus.step_order_o); end
    bus.step_ready_i = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      checks++; if (bus.step_valid_o !== 1'b1 || bus.step_order_o !== 64'(20 + i) || count !== 4'(DEPTH - i)) begin
        failures++; $display("FAIL ovf_drain[%0d] got=valid%b order%0d count%0d exp=valid1 order%0d count%0d", i, bus.step_valid_o, bus.step_order_o, count, 20 + i, DEPTH - i);
      end
    end
    tick();
    checks++; if (bus.step_valid_o !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL ovf_last_dropped got=valid%b order%0d exp=valid0", bus.step_valid_o, bus.step_order_o); end
    bus.step_ready_i = 1'b0;
  endtask

  task automatic test_order_err();
    logic [63:0] seq [3];
    seq[0] = 64'd5; seq[1] = 64'd6; seq[2] = 64'd8;
    do_reset();
    bus.step_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, seq[k], 1'b0, 32'd0);
      tick();
      checks++; if (bus.step_valid_o !== 1'b1 || bus.step_order_o !== seq[k]) begin failures++; $display("FAIL oerr_deliver[%0d] got=valid%b order%0d exp=valid1 order%0d", k, bus.step_valid_o, bus.step_order_o, seq[k]); end
      checks++; if (order_err !== (k == 2)) begin failures++; $display("FAIL oerr_flag[%0d] got=%b exp=%b", k, order_err, k == 2); end
    end
    drive(1'b0, 64'd0, 1'b0, 32'd0);
    tick();
    checks++; if (order_err !== 1'b1 || bus.step_valid_o !== 1'b0) begin failures++; $display("FAIL oerr_sticky got=err%b valid%b exp=err1 valid0", order_err, bus.step_valid_o); end
    bus.step_ready_i = 1'b0;
  endtask

  task automatic test_full_pop_and_reset();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 64'(30 + k), 1'b0, 32'd0);
      tick();
    end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL fullpop_pre_count got=%0d exp=8", count); end
    drive(1'b1, 64'd38, 1'b0, 32'd0);
    bus.step_ready_i = 1'b1;
    tick();
    drive(1'b0, 64'd0, 1'b0, 32'd0);
    bus.step_ready_i = 1'b0;
    checks++; if (count !== 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL fullpop_count got=count%0d ovf%b exp=count8 ovf0", count, overflow); end
    checks++; if (bus.step_valid_o !== 1'b1 || bus.step_order_o !== 64'd31) begin failures++; $display("FAIL fullpop_head got=valid%b order%0d exp=valid1 order31", bus.step_valid_o, bus.step_order_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.step_valid_o !== 1'b0 || bus.intr_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valids got=step%b intr%b exp=00", bus.step_valid_o, bus.intr_valid_o); end
    checks++; if (count !== 4'd0 || bus.step_order_o !== 64'd0) begin failures++; $display("FAIL midrst_state got=count%0d order%0d exp=0 0", count, bus.step_order_o); end
    checks++; if (overflow !== 1'b0 || order_err !== 1'b0) begin failures++; $display("FAIL midrst_sticky got=%b%b exp=00", overflow, order_err); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_intr();
    test_back_to_back();
    test_overflow();
    test_order_err();
    test_full_pop_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
